// File: rtl/gba_sound_pkg.sv
// Shared constants for the direct-sound FIFOs: channel addresses, bus size codes, refill threshold.
// Also holds the little-endian byte selector used to pick a sample out of a stored word.
package gba_sound_pkg;

  localparam logic [31:0] FIFO_A_ADDR = 32'h0400_00A0;
  localparam logic [31:0] FIFO_B_ADDR = 32'h0400_00A4;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int REQ_THRESH_DEF = 4;

  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

endpackage

// File: rtl/sound_word_fifo.sv
// DEPTH x 32 word store; push lands next clock, head word is read combinationally.
// A push into a full FIFO is dropped unless a pop in the same cycle frees a slot.
module sound_word_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic                    clear_i,
  input  logic [31:0]             wdata_i,
  output logic [31:0]             rdata_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic                    push_ok_o,
  output logic [$clog2(DEPTH):0]  level_o,
  output logic [$clog2(DEPTH):0]  level_nxt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          push_ok, pop_ok;

  assign full_o      = (level_q == LW'(DEPTH));
  assign empty_o     = (level_q == '0);
  assign pop_ok      = pop_i & ~empty_o;
  assign push_ok     = push_i & (~full_o | pop_ok);
  assign push_ok_o   = push_ok;
  assign rdata_o     = mem_q[rd_ptr_q];
  assign level_o     = level_q;
  assign level_nxt_o = level_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      level_d = level_q + LW'(push_ok) - LW'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: level gates every read of it.
  always_ff @(posedge clk) begin
    if (push_ok && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/dma_sound_fifo.sv
// Direct-sound channel FIFO: bus write decode, halfword staging, per-tick sample output, refill request.
// Zero wait states; samples and flag pulses are registered one clock after the causing event.
module dma_sound_fifo
  import gba_sound_pkg::*;
#(
  parameter logic [31:0] FIFO_ADDR  = FIFO_A_ADDR,
  parameter int          DEPTH      = 8,
  parameter int          REQ_THRESH = REQ_THRESH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    bus_valid,
  input  logic [31:0]             bus_addr,
  input  logic [31:0]             bus_wdata,
  input  logic [1:0]              bus_size,
  input  logic                    bus_wen,
  input  logic                    fifo_clear,
  input  logic                    req_en,
  input  logic                    timer_tick,
  output logic [7:0]              sample_out,
  output logic                    sound_req,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic                    underflow
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          addr_hit, word_wr, half_wr, half_hi;
  logic          push, pop, tick_ok;
  logic [31:0]   push_data, head_word;
  logic          full, empty, push_ok;
  logic [LW-1:0] level_nxt;
  logic          unused_addr0;

  logic [15:0] stage_q, stage_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  sample_q, sample_d;
  logic        req_q, req_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;

  assign addr_hit  = bus_valid & bus_wen & (bus_addr[31:2] == FIFO_ADDR[31:2]);
  assign word_wr   = addr_hit & (bus_size == SIZE_WORD);
  assign half_wr   = addr_hit & (bus_size == SIZE_HALF);
  assign half_hi   = half_wr & bus_addr[1];
  assign push      = word_wr | half_hi;
  assign push_data = word_wr ? bus_wdata : {bus_wdata[31:16], stage_q};
  assign tick_ok   = timer_tick & ~empty;
  assign pop       = tick_ok & (byte_idx_q == 2'd3);
  assign unused_addr0 = bus_addr[0];

  sound_word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_b       (rst_b),
    .push_i      (push),
    .pop_i       (pop),
    .clear_i     (fifo_clear),
    .wdata_i     (push_data),
    .rdata_o     (head_word),
    .full_o      (full),
    .empty_o     (empty),
    .push_ok_o   (push_ok),
    .level_o     (level),
    .level_nxt_o (level_nxt)
  );

  // Clear wins over everything in the same cycle, including flag pulses.
  always_comb begin
    stage_d    = stage_q;
    byte_idx_d = byte_idx_q;
    sample_d   = sample_q;
    req_d      = 1'b0;
    ovf_d      = 1'b0;
    unf_d      = 1'b0;
    if (fifo_clear) begin
      stage_d    = '0;
      byte_idx_d = '0;
      sample_d   = '0;
    end else begin
      if (half_wr) stage_d = half_hi ? 16'h0000 : bus_wdata[15:0];
      if (tick_ok) begin
        sample_d   = word_byte(head_word, byte_idx_q);
        byte_idx_d = byte_idx_q + 2'd1;
      end
      unf_d = timer_tick & empty;
      ovf_d = push & ~push_ok;
      req_d = pop & req_en & (level_nxt <= LW'(REQ_THRESH));
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      stage_q    <= '0;
      byte_idx_q <= '0;
      sample_q   <= '0;
      req_q      <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      stage_q    <= stage_d;
      byte_idx_q <= byte_idx_d;
      sample_q   <= sample_d;
      req_q      <= req_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign sample_out = sample_q;
  assign sound_req  = req_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;

endmodule

// File: tb/tb_dma_sound_fifo.sv
// Directed bench for dma_sound_fifo (FIFO_A, DEPTH 8, threshold 4) with hand-computed expectations.
module tb_dma_sound_fifo;
  import gba_sound_pkg::*;

  localparam logic [31:0] A = FIFO_A_ADDR;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        bus_valid, bus_wen, fifo_clear, req_en, timer_tick;
  logic [31:0] bus_addr, bus_wdata;
  logic [1:0]  bus_size;
  logic [7:0]  sample_out;
  logic        sound_req, overflow, underflow;
  logic [3:0]  level;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dma_sound_fifo dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .bus_valid  (bus_valid),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_size   (bus_size),
    .bus_wen    (bus_wen),
    .fifo_clear (fifo_clear),
    .req_en     (req_en),
    .timer_tick (timer_tick),
    .sample_out (sample_out),
    .sound_req  (sound_req),
    .level      (level),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus_valid = 1'b0;
    bus_wen   = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_size  = '0;
  endtask

  task automatic bus_set(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
    bus_valid = 1'b1;
    bus_wen   = 1'b1;
    bus_addr  = addr;
    bus_wdata = data;
    bus_size  = size;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
    bus_set(addr, data, size);
    step();
    bus_idle();
  endtask

  task automatic tick();
    timer_tick = 1'b1;
    step();
    timer_tick = 1'b0;
  endtask

  task automatic check_flags(input string tag, input logic r, input logic o, input logic u);
    chk({tag, "_req"}, 32'(sound_req), 32'(r));
    chk({tag, "_ovf"}, 32'(overflow), 32'(o));
    chk({tag, "_unf"}, 32'(underflow), 32'(u));
  endtask

  // Four ticks consume word w; optionally a word push rides on the popping tick.
  task automatic drain_word(input string tag, input logic [31:0] w, input logic do_push,
                            input logic [31:0] pw, input int exp_lvl, input logic exp_req);
    logic [31:0] wb;
    wb = w;
    for (int b = 0; b < 4; b++) begin
      if (b == 3 && do_push) bus_set(A, pw, SIZE_WORD);
      tick();
      bus_idle();
      chk({tag, "_smp"}, 32'(sample_out), 32'(wb[8*b +: 8]));
    end
    chk({tag, "_lvl"}, 32'(level), 32'(exp_lvl));
    check_flags({tag, "_pop"}, exp_req, 1'b0, 1'b0);
    step();
    chk({tag, "_req_end"}, 32'(sound_req), 32'h0);
  endtask

  initial begin
    rst_b      = 1'b0;
    fifo_clear = 1'b0;
    req_en     = 1'b1;
    timer_tick = 1'b0;
    bus_idle();
    #12;
    chk("rst_smp", 32'(sample_out), 32'h0);
    chk("rst_lvl", 32'(level), 32'h0);
    check_flags("rst", 1'b0, 1'b0, 1'b0);
    rst_b = 1'b1;

    // Word pushes and little-endian sample order
    wr(A, 32'h0403_0201, SIZE_WORD);
    wr(A, 32'h0807_0605, SIZE_WORD);
    wr(A, 32'h0C0B_0A09, SIZE_WORD);
    wr(A, 32'h100F_0E0D, SIZE_WORD);
    chk("fill4_lvl", 32'(level), 32'h4);
    chk("fill4_smp", 32'(sample_out), 32'h0);
    chk("fill4_req", 32'(sound_req), 32'h0);
    drain_word("w0", 32'h0403_0201, 1'b0, 32'h0, 3, 1'b1);
    req_en = 1'b0;
    drain_word("w1_noreq", 32'h0807_0605, 1'b0, 32'h0, 2, 1'b0);
    req_en = 1'b1;

    // Halfword staging, orphan high half, ignored byte and size-11 writes
    wr(A, 32'h0000_BEEF, SIZE_HALF);
    chk("half_lo_lvl", 32'(level), 32'h2);
    wr(A + 32'd2, 32'hDEAD_0000, SIZE_HALF);
    chk("half_hi_lvl", 32'(level), 32'h3);
    wr(A + 32'd2, 32'h1234_5678, SIZE_HALF);
    chk("half_orphan_lvl", 32'(level), 32'h4);
    wr(A, 32'h5555_5555, SIZE_BYTE);
    chk("byte_lvl", 32'(level), 32'h4);
    wr(A, 32'h6666_6666, 2'b11);
    chk("size11_lvl", 32'(level), 32'h4);
    wr(A + 32'd4, 32'h7777_7777, SIZE_WORD);
    chk("other_addr_lvl", 32'(level), 32'h4);
    drain_word("w2", 32'h0C0B_0A09, 1'b0, 32'h0, 3, 1'b1);
    drain_word("w3", 32'h100F_0E0D, 1'b0, 32'h0, 2, 1'b1);
    drain_word("half", 32'hDEAD_BEEF, 1'b0, 32'h0, 1, 1'b1);
    drain_word("orphan", 32'h1234_0000, 1'b0, 32'h0, 0, 1'b1);

    // Full FIFO: dropped push, then push accepted alongside a pop
    for (int i = 0; i < 8; i++) wr(A, 32'hC3C2_C1C0 + 32'h0101_0101 * 32'(i), SIZE_WORD);
    chk("full_lvl", 32'(level), 32'h8);
    wr(A, 32'hEEEE_EEEE, SIZE_WORD);
    chk("ovf_lvl", 32'(level), 32'h8);
    check_flags("ovf", 1'b0, 1'b1, 1'b0);
    step();
    chk("ovf_end", 32'(overflow), 32'h0);
    drain_word("full_pop", 32'hC3C2_C1C0, 1'b1, 32'hF3F2_F1F0, 8, 1'b0);
    for (int i = 1; i < 8; i++)
      drain_word("full_drain", 32'hC3C2_C1C0 + 32'h0101_0101 * 32'(i), 1'b0, 32'h0, 8 - i, (8 - i) <= 4);
    drain_word("late", 32'hF3F2_F1F0, 1'b0, 32'h0, 0, 1'b1);

    // Underflow holds the last sample
    tick();
    chk("unf_smp", 32'(sample_out), 32'hF3);
    chk("unf_lvl", 32'(level), 32'h0);
    check_flags("unf", 1'b0, 1'b0, 1'b1);
    step();
    chk("unf_end", 32'(underflow), 32'h0);

    // Pointer wrap: 20 words kept three deep, push rides each pop
    for (int k = 0; k < 3; k++) wr(A, 32'h0302_0100 + 32'h0404_0404 * 32'(k), SIZE_WORD);
    for (int k = 0; k < 17; k++)
      drain_word("wrap", 32'h0302_0100 + 32'h0404_0404 * 32'(k), 1'b1,
                 32'h0302_0100 + 32'h0404_0404 * 32'(k + 3), 3, 1'b1);
    drain_word("wrap_t0", 32'h4746_4544, 1'b0, 32'h0, 2, 1'b1);
    drain_word("wrap_t1", 32'h4B4A_4948, 1'b0, 32'h0, 1, 1'b1);
    drain_word("wrap_t2", 32'h4F4E_4D4C, 1'b0, 32'h0, 0, 1'b1);

    // Clear with same-cycle push and tick
    wr(A, 32'h4433_2211, SIZE_WORD);
    wr(A, 32'h8877_6655, SIZE_WORD);
    tick();
    chk("pre_clr_smp", 32'(sample_out), 32'h11);
    fifo_clear = 1'b1;
    timer_tick = 1'b1;
    bus_set(A, 32'h9999_9999, SIZE_WORD);
    step();
    fifo_clear = 1'b0;
    timer_tick = 1'b0;
    bus_idle();
    chk("clr_lvl", 32'(level), 32'h0);
    chk("clr_smp", 32'(sample_out), 32'h0);
    check_flags("clr", 1'b0, 1'b0, 1'b0);
    wr(A, 32'h0000_BEEF, SIZE_HALF);
    fifo_clear = 1'b1;
    step();
    fifo_clear = 1'b0;
    wr(A + 32'd2, 32'hDEAD_0000, SIZE_HALF);
    chk("clr_stage_lvl", 32'(level), 32'h1);
    drain_word("clr_stage", 32'hDEAD_0000, 1'b0, 32'h0, 0, 1'b1);

    // Asynchronous reset mid-stream
    wr(A, 32'hA1A2_A3A4, SIZE_WORD);
    wr(A, 32'hB1B2_B3B4, SIZE_WORD);
    tick();
    chk("pre_rst_smp", 32'(sample_out), 32'hA4);
    #2 rst_b = 1'b0;
    #1;
    chk("arst_smp", 32'(sample_out), 32'h0);
    chk("arst_lvl", 32'(level), 32'h0);
    check_flags("arst", 1'b0, 1'b0, 1'b0);
    #3 rst_b = 1'b1;
    step();
    chk("post_rst_lvl", 32'(level), 32'h0);
    tick();
    check_flags("post_rst_tick", 1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
